// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipe_defs;

  // Multiply/divide unit occupancy state.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  // tuse encoding meaning "this source register is not read".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default HI/LO busy windows, in cycles after the op issues in E.
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Width of the busy-window down-counter.
  localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-controller bus: D/E/M timing info in, stall/enable controls out.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic [1:0]       tuse_rs_D;
  logic [1:0]       tuse_rt_D;
  logic [4:0]       a_E;
  logic [4:0]       a_M;
  logic [1:0]       tnew_E;
  logic [1:0]       tnew_M;
  logic             md_start_E;
  logic             md_is_div_E;
  logic             md_use_D;
  logic             pc_en;
  logic             fd_en;
  logic             de_clr;
  logic             md_busy;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: supplies register-use timing, receives enables.
  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a_E, a_M, tnew_E, tnew_M,
           md_start_E, md_is_div_E, md_use_D,
    input  pc_en, fd_en, de_clr, md_busy, stall, stall_cnt
  );

  // Controller side.
  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a_E, a_M, tnew_E, tnew_M,
           md_start_E, md_is_div_E, md_use_D,
    output pc_en, fd_en, de_clr, md_busy, stall, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// Tracks the HI/LO busy window following a mult/div issue in E.
module md_busy_timer
  import pipe_defs::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_is_div_E,
  output logic md_busy
);
  localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_LAT);
  localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_LAT);

  md_state_t           state, state_nxt;
  logic [MD_CNT_W-1:0] cnt, cnt_nxt;

  // State and counter register; reset abandons any window in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a new issue always (re)loads the window, latest op wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (md_start_E) begin
      state_nxt = md_is_div_E ? MD_DIV : MD_MUL;
      cnt_nxt   = md_is_div_E ? DIV_CNT : MULT_CNT;
    end else begin
      case (state)
        MD_MUL, MD_DIV: begin
          if (cnt == MD_CNT_W'(1)) begin
            state_nxt = MD_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - MD_CNT_W'(1);
          end
        end
        default: begin
          state_nxt = MD_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Busy covers the issue cycle itself plus the counted window; never in reset.
  assign md_busy = reset & (md_start_E | (state != MD_IDLE));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: freezes PC and F/D,
// bubbles D/E, and counts stalled cycles.
module hazard_stall_ctrl
  import pipe_defs::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);
  logic             md_busy_w;
  logic             rs_stall;
  logic             rt_stall;
  logic             md_stall;
  logic             stall_w;
  logic [CNT_W-1:0] stall_cnt_q;

  // A source stalls when a producer in E or M will not have its result
  // ready by the time D needs it. $0 and unused sources never stall.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a_e,
    input logic [1:0] tnew_e,
    input logic [4:0] a_m,
    input logic [1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == a_e) && (tuse < tnew_e);
    hit_m = (src == a_m) && (tuse < tnew_m);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_timer (
    .clk         (clk),
    .reset       (reset),
    .md_start_E  (bus.md_start_E),
    .md_is_div_E (bus.md_is_div_E),
    .md_busy     (md_busy_w)
  );

  // Hazard detection and stall decision; all stalls are suppressed in reset.
  always_comb begin
    rs_stall = src_hazard(bus.rs_D, bus.tuse_rs_D, bus.a_E, bus.tnew_E,
                          bus.a_M, bus.tnew_M);
    rt_stall = src_hazard(bus.rt_D, bus.tuse_rt_D, bus.a_E, bus.tnew_E,
                          bus.a_M, bus.tnew_M);
    md_stall = bus.md_use_D & md_busy_w;
    stall_w  = reset & (rs_stall | rt_stall | md_stall);
  end

  // Saturating stall-cycle counter: one count per stalled cycle regardless
  // of how many stall causes coincide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall     = stall_w;
  assign bus.pc_en     = ~stall_w;
  assign bus.fd_en     = ~stall_w;
  assign bus.de_clr    = stall_w;
  assign bus.md_busy   = md_busy_w;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a
// randomized run against a cycle-indexed behavioural model.
module tb_hazard_stall_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  hazard_stall_ctrl_if #(.CNT_W(32)) ifm ();
  hazard_stall_ctrl_if #(.CNT_W(4))  ifs ();

  hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm.slave)
  );

  hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (ifs.slave)
  );

  assign ifs.rs_D        = ifm.rs_D;
  assign ifs.rt_D        = ifm.rt_D;
  assign ifs.tuse_rs_D   = ifm.tuse_rs_D;
  assign ifs.tuse_rt_D   = ifm.tuse_rt_D;
  assign ifs.a_E         = ifm.a_E;
  assign ifs.a_M         = ifm.a_M;
  assign ifs.tnew_E      = ifm.tnew_E;
  assign ifs.tnew_M      = ifm.tnew_M;
  assign ifs.md_start_E  = ifm.md_start_E;
  assign ifs.md_is_div_E = ifm.md_is_div_E;
  assign ifs.md_use_D    = ifm.md_use_D;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: busy window kept as "last busy cycle index".
  int cyc       = 0;
  int busy_last = -1;
  int mdl_cnt   = 0;

  function automatic bit hz(input logic [4:0] r, input logic [1:0] tu);
    if (r == 5'd0 || tu == 2'd3) return 1'b0;
    return (r == ifm.a_E && tu < ifm.tnew_E) || (r == ifm.a_M && tu < ifm.tnew_M);
  endfunction

  function automatic bit mdl_busy();
    return reset && (ifm.md_start_E || cyc <= busy_last);
  endfunction

  function automatic bit mdl_stall();
    return reset && (hz(ifm.rs_D, ifm.tuse_rs_D) || hz(ifm.rt_D, ifm.tuse_rt_D) ||
                     (ifm.md_use_D && mdl_busy()));
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      busy_last <= -1;
      mdl_cnt   <= 0;
    end else begin
      if (ifm.md_start_E)
        busy_last <= cyc + (ifm.md_is_div_E ? DIV_LAT : MULT_LAT);
      if (mdl_stall())
        mdl_cnt <= mdl_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic idle_inputs();
    ifm.rs_D = 0; ifm.rt_D = 0; ifm.tuse_rs_D = 2'd3; ifm.tuse_rt_D = 2'd3;
    ifm.a_E = 0; ifm.a_M = 0; ifm.tnew_E = 0; ifm.tnew_M = 0;
    ifm.md_start_E = 0; ifm.md_is_div_E = 0; ifm.md_use_D = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b0;
    ifm.rs_D = 8; ifm.tuse_rs_D = 0; ifm.a_E = 8; ifm.tnew_E = 2;
    ifm.md_start_E = 1; ifm.md_use_D = 1;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b exp 0", ifm.stall); end
    n_chk++; if (ifm.pc_en !== 1'b1) begin n_fail++; $display("FAIL rst_pc_en got %0b exp 1", ifm.pc_en); end
    n_chk++; if (ifm.fd_en !== 1'b1) begin n_fail++; $display("FAIL rst_fd_en got %0b exp 1", ifm.fd_en); end
    n_chk++; if (ifm.de_clr !== 1'b0) begin n_fail++; $display("FAIL rst_de_clr got %0b exp 0", ifm.de_clr); end
    n_chk++; if (ifm.md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_md_busy got %0b exp 0", ifm.md_busy); end
    tick();
    tick();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (ifm.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", ifm.stall_cnt); end
    n_chk++; if (ifm.md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got %0b exp 0", ifm.md_busy); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ifm.rs_D = 8; ifm.tuse_rs_D = 0; ifm.a_E = 8; ifm.tnew_E = 2;
    @(negedge clk);
    n_chk++; if ({ifm.stall, ifm.pc_en, ifm.fd_en, ifm.de_clr} !== 4'b1001) begin
      n_fail++; $display("FAIL lu_e got stall/pc/fd/clr=%b exp 1001", {ifm.stall, ifm.pc_en, ifm.fd_en, ifm.de_clr});
    end
    tick();
    ifm.a_E = 0; ifm.tnew_E = 0; ifm.a_M = 8; ifm.tnew_M = 1;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b1) begin n_fail++; $display("FAIL lu_m got %0b exp 1", ifm.stall); end
    tick();
    ifm.tnew_M = 0;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b0) begin n_fail++; $display("FAIL lu_ready got %0b exp 0", ifm.stall); end
    n_chk++; if (ifm.stall_cnt !== 32'd2) begin n_fail++; $display("FAIL lu_cnt got %0d exp 2", ifm.stall_cnt); end
    tick();
  endtask

  task automatic test_no_false_stall();
    do_reset();
    ifm.rs_D = 0; ifm.tuse_rs_D = 0; ifm.a_E = 0; ifm.tnew_E = 2;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b0) begin n_fail++; $display("FAIL nf_r0 got %0b exp 0", ifm.stall); end
    tick();
    ifm.rt_D = 9; ifm.tuse_rt_D = 3; ifm.a_E = 9; ifm.tnew_E = 2;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b0) begin n_fail++; $display("FAIL nf_tuse3 got %0b exp 0", ifm.stall); end
    tick();
    ifm.tuse_rt_D = 1; ifm.tnew_E = 1;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b0) begin n_fail++; $display("FAIL nf_equal got %0b exp 0", ifm.stall); end
    tick();
    ifm.tnew_E = 2;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b1) begin n_fail++; $display("FAIL nf_rt_hit got %0b exp 1", ifm.stall); end
    tick();
  endtask

  task automatic test_mult_window();
    do_reset();
    ifm.md_use_D = 1; ifm.md_start_E = 1; ifm.md_is_div_E = 0;
    for (int k = 0; k <= MULT_LAT + 1; k++) begin
      @(negedge clk);
      n_chk++; if (ifm.md_busy !== (k <= MULT_LAT)) begin
        n_fail++; $display("FAIL mul_busy t+%0d got %0b exp %0b", k, ifm.md_busy, k <= MULT_LAT);
      end
      n_chk++; if (ifm.stall !== (k <= MULT_LAT)) begin
        n_fail++; $display("FAIL mul_stall t+%0d got %0b exp %0b", k, ifm.stall, k <= MULT_LAT);
      end
      tick();
      ifm.md_start_E = 0;
    end
    n_chk++; if (ifm.stall_cnt !== 32'(MULT_LAT + 1)) begin
      n_fail++; $display("FAIL mul_cnt got %0d exp %0d", ifm.stall_cnt, MULT_LAT + 1);
    end
  endtask

  task automatic test_div_reset();
    do_reset();
    ifm.md_use_D = 1; ifm.md_start_E = 1; ifm.md_is_div_E = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++; if (ifm.md_busy !== 1'b1) begin n_fail++; $display("FAIL divr_busy t+%0d got %0b exp 1", k, ifm.md_busy); end
      tick();
      ifm.md_start_E = 0;
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if ({ifm.md_busy, ifm.stall, ifm.pc_en} !== 3'b001) begin
      n_fail++; $display("FAIL divr_in_rst got busy/stall/pc=%b exp 001", {ifm.md_busy, ifm.stall, ifm.pc_en});
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (ifm.md_busy !== 1'b0) begin n_fail++; $display("FAIL divr_after got %0b exp 0", ifm.md_busy); end
    n_chk++; if (ifm.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL divr_cnt got %0d exp 0", ifm.stall_cnt); end
    tick();
    ifm.md_start_E = 1; ifm.md_is_div_E = 1;
    for (int k = 0; k <= DIV_LAT + 1; k++) begin
      @(negedge clk);
      n_chk++; if (ifm.md_busy !== (k <= DIV_LAT)) begin
        n_fail++; $display("FAIL div_busy t+%0d got %0b exp %0b", k, ifm.md_busy, k <= DIV_LAT);
      end
      tick();
      ifm.md_start_E = 0;
    end
  endtask

  task automatic test_overlap();
    do_reset();
    ifm.md_use_D = 1; ifm.md_start_E = 1; ifm.md_is_div_E = 0;
    ifm.rs_D = 8; ifm.tuse_rs_D = 0; ifm.a_E = 8; ifm.tnew_E = 2;
    @(negedge clk);
    n_chk++; if (ifm.stall !== 1'b1) begin n_fail++; $display("FAIL ovl_stall got %0b exp 1", ifm.stall); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_chk++; if (ifm.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL ovl_cnt got %0d exp 1", ifm.stall_cnt); end
    n_chk++; if ({ifm.md_busy, ifm.stall} !== 2'b10) begin
      n_fail++; $display("FAIL ovl_busy got busy/stall=%b exp 10", {ifm.md_busy, ifm.stall});
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ifm.rs_D = 8; ifm.tuse_rs_D = 0; ifm.a_E = 8; ifm.tnew_E = 2;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      n_chk++; if (ifs.stall_cnt !== 4'((k > 15) ? 15 : k)) begin
        n_fail++; $display("FAIL sat_small k=%0d got %0d exp %0d", k, ifs.stall_cnt, (k > 15) ? 15 : k);
      end
      n_chk++; if (ifm.stall_cnt !== 32'(k)) begin
        n_fail++; $display("FAIL sat_wide k=%0d got %0d exp %0d", k, ifm.stall_cnt, k);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] exp_cnt;
    logic [3:0]  exp_cnt_s;
    logic        exp_stall;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 59) != 0);
      ifm.rs_D        = 5'($urandom_range(0, 3));
      ifm.rt_D        = 5'($urandom_range(0, 3));
      ifm.tuse_rs_D   = 2'($urandom_range(0, 3));
      ifm.tuse_rt_D   = 2'($urandom_range(0, 3));
      ifm.a_E         = 5'($urandom_range(0, 3));
      ifm.a_M         = 5'($urandom_range(0, 3));
      ifm.tnew_E      = 2'($urandom_range(0, 3));
      ifm.tnew_M      = 2'($urandom_range(0, 3));
      ifm.md_start_E  = ($urandom_range(0, 11) == 0);
      ifm.md_is_div_E = 1'($urandom_range(0, 1));
      ifm.md_use_D    = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp_stall = mdl_stall();
      exp_cnt   = 32'(mdl_cnt);
      exp_cnt_s = 4'((mdl_cnt > 15) ? 15 : mdl_cnt);
      n_chk++; if (ifm.stall !== exp_stall) begin
        n_fail++; $display("FAIL rnd_stall i=%0d got %0b exp %0b", i, ifm.stall, exp_stall);
      end
      n_chk++; if ({ifm.pc_en, ifm.fd_en, ifm.de_clr} !== {~exp_stall, ~exp_stall, exp_stall}) begin
        n_fail++; $display("FAIL rnd_ctl i=%0d got pc/fd/clr=%b exp %b", i,
                           {ifm.pc_en, ifm.fd_en, ifm.de_clr}, {~exp_stall, ~exp_stall, exp_stall});
      end
      n_chk++; if (ifm.md_busy !== mdl_busy()) begin
        n_fail++; $display("FAIL rnd_busy i=%0d got %0b exp %0b", i, ifm.md_busy, mdl_busy());
      end
      n_chk++; if (ifm.stall_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL rnd_cnt i=%0d got %0d exp %0d", i, ifm.stall_cnt, exp_cnt);
      end
      n_chk++; if (ifs.stall_cnt !== exp_cnt_s) begin
        n_fail++; $display("FAIL rnd_cnt_sat i=%0d got %0d exp %0d", i, ifs.stall_cnt, exp_cnt_s);
      end
      tick();
    end
    idle_inputs();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_mult_window();
    test_div_reset();
    test_overlap();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
